alu: RTL and testbench
======================

// Module: alu
// PURPOSE
// - 32-bit integer ALU for the Pasithea PE datapath: 16 ops selected by ALU_Sel.
// - Operands are sampled on a valid strobe; result, carry and zero flags are registered.
// - Latency is one cycle. Consumed by PE writeback and branch/compare logic.
// PARAMETERS
// - WIDTH  32  datapath width; all ops are defined for WIDTH=32, shift amount = B[4:0]
// PORTS
// - clk       in   1   single clock, rising edge
// - rst       in   1   reset, synchronous, active-high
// - in_valid  in   1   operands/opcode valid this cycle
// - A         in   32  operand A
// - B         in   32  operand B / shift amount (B[4:0])
// - ALU_Sel   in   4   opcode
// - out_valid out  1   registered in_valid; result valid this cycle
// - ALU_Out   out  32  registered result
// - CarryOut  out  1   registered carry/borrow flag
// - Zero      out  1   registered (ALU_Out == 0)
// BEHAVIOUR
// - Reset: if rst is high at a rising edge, out_valid=0, ALU_Out=0, CarryOut=0, Zero=1.
//   Reset overrides in_valid in the same cycle. Any in-flight result is discarded.
// - in_valid=1 at edge: all outputs load the new result; out_valid=1 next cycle.
// - in_valid=0 at edge: out_valid=0; ALU_Out, CarryOut and Zero hold their last values.
// - No backpressure. A new op may be issued every cycle.
// - Opcodes (results are 32-bit; all arithmetic wraps mod 2^32):
//   0000 ADD  A+B; CarryOut = bit 32 of the 33-bit sum
//   0001 SUB  A-B; CarryOut = borrow (1 iff A<B unsigned)
//   0010 MUL  low 32 bits of A*B (unsigned); CarryOut=0
//   0011 DIVU A/B unsigned; B==0 -> 32'hFFFFFFFF; CarryOut=0
//   0100 SLL  A << B[4:0]
//   0101 SRL  A >> B[4:0] (logical)
//   0110 ROL  rotate A left by B[4:0]; 0 -> A unchanged
//   0111 ROR  rotate A right by B[4:0]
//   1000 AND  1001 OR  1010 XOR  1011 NOR  1100 NAND (bitwise)
//   1101 SLTU (A<B unsigned) ? 1 : 0
//   1110 SLT  ($signed(A) < $signed(B)) ? 1 : 0
//   1111 SRA  $signed(A) >>> B[4:0]
// - CarryOut is 0 for every opcode except ADD and SUB.
// - Zero is computed from the same-cycle result, never from the previous output.
// - B[31:5] are ignored for all shift and rotate ops.
// CONFIGURATION
// - ALU_MULDIV_EN defined: MUL and DIVU are implemented as above (single-cycle combinational).
// - ALU_MULDIV_EN undefined: opcodes 0010/0011 return 0 with CarryOut=0 and Zero=1.
//   No multiplier or divider logic is synthesized. All other opcodes are unchanged.
// TESTING
// - Reset: hold rst 2 cycles -> out_valid=0, ALU_Out=0, CarryOut=0, Zero=1.
// - ADD/SUB carry:
//   - 5+3 -> 8, C=0
//   - FFFFFFFF+1 -> 0, C=1, Z=1
//   - 5-3 -> 2, C=0
//   - 3-5 -> FFFFFFFE, C=1
// - MUL/DIV with ALU_MULDIV_EN: 2*3 -> 6; 6/2 -> 3; 6/0 -> FFFFFFFF.
//   Without ALU_MULDIV_EN: 2*3 -> 0, Z=1.
// - Shift/rotate:
//   - SLL 1 by 4 -> 10
//   - SRL 2 by 1 -> 1
//   - ROL 80000000 by 1 -> 1
//   - ROR 80000000 by 1 -> 40000000
//   - SRA -8 by 2 -> FFFFFFFE
// - Logic with A=F0F0F0F0, B=0F0F0F0F:
//   - AND -> 0, Z=1
//   - OR -> FFFFFFFF
//   - XOR -> FFFFFFFF
//   - NOR -> 0
//   - NAND -> FFFFFFFF
// - Compare/timing:
//   - SLTU 5,10 -> 1
//   - SLT -5,-10 -> 0
//   - SLTU FFFFFFFB,5 -> 0
//   - back-to-back ops each appear exactly 1 cycle later
//   - in_valid=0 holds prior outputs

Source files
------------

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : 32-bit registered integer ALU, 16 opcodes, one-cycle latency.
//               Define ALU_MULDIV_EN to build the MUL/DIVU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIVU = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_SRA  = 4'b1111;

  logic             valid_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_sh;
  logic [SHW-1:0]   w_nsh;

  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};
  assign w_sh   = B[SHW-1:0];
  // Complementary rotate distance; wraps to 0 when w_sh is 0 so rotates by 0 return A.
  assign w_nsh  = SHW'(0) - w_sh;

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    unique case (ALU_Sel)
      OP_ADD: begin
        res_d   = w_sum[WIDTH-1:0];
        carry_d = w_sum[WIDTH];
      end
      OP_SUB: begin
        res_d   = w_diff[WIDTH-1:0];
        carry_d = w_diff[WIDTH];
      end
`ifdef ALU_MULDIV_EN
      OP_MUL:  res_d = A * B;
      OP_DIVU: res_d = (B == '0) ? '1 : (A / B);
`else
      OP_MUL:  res_d = '0;
      OP_DIVU: res_d = '0;
`endif
      OP_SLL:  res_d = A << w_sh;
      OP_SRL:  res_d = A >> w_sh;
      OP_ROL:  res_d = (A << w_sh) | (A >> w_nsh);
      OP_ROR:  res_d = (A >> w_sh) | (A << w_nsh);
      OP_AND:  res_d = A & B;
      OP_OR:   res_d = A | B;
      OP_XOR:  res_d = A ^ B;
      OP_NOR:  res_d = ~(A | B);
      OP_NAND: res_d = ~(A & B);
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SRA:  res_d = $signed(A) >>> w_sh;
      default: res_d = '0;
    endcase
    zero_d = (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q   <= res_d;
        carry_q <= carry_d;
        zero_q  <= zero_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign ALU_Out   = res_q;
  assign CarryOut  = carry_q;
  assign Zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu
// Description : Directed plus randomized self-checking bench for alu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_Sel;
  logic        out_valid;
  logic [31:0] ALU_Out;
  logic        CarryOut;
  logic        Zero;

  int checks = 0;
  int errors = 0;
  logic [31:0] hold_r;
  logic        hold_c;

  always #5 clk = ~clk;

  alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .out_valid(out_valid),
    .ALU_Out  (ALU_Out),
    .CarryOut (CarryOut),
    .Zero     (Zero)
  );

  // Reference model: returns {carry, result} computed with 64-bit arithmetic.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] s);
    longint unsigned ua, ub, t, m;
    longint          sl;
    int              sa, sb, sh;
    logic            c;
    ua = a; ub = b; m = 64'hFFFF_FFFF;
    sa = a; sb = b; sh = int'(b[4:0]);
    c  = 1'b0; t = 0;
    case (s)
      4'd0: begin t = ua + ub; c = (t > m); end
      4'd1: begin t = (ua - ub) & m; c = (ua < ub); end
`ifdef ALU_MULDIV_EN
      4'd2: t = (ua * ub) & m;
      4'd3: t = (ub == 0) ? m : ua / ub;
`else
      4'd2: t = 0;
      4'd3: t = 0;
`endif
      4'd4: t = (ua << sh) & m;
      4'd5: t = ua >> sh;
      4'd6: t = ((ua << sh) | (ua >> (32 - sh))) & m;
      4'd7: t = ((ua >> sh) | (ua << (32 - sh))) & m;
      4'd8: t = ua & ub;
      4'd9: t = ua | ub;
      4'd10: t = ua ^ ub;
      4'd11: t = ~(ua | ub) & m;
      4'd12: t = ~(ua & ub) & m;
      4'd13: t = (ua < ub) ? 1 : 0;
      4'd14: t = (sa < sb) ? 1 : 0;
      default: begin sl = sa; sl = sl >>> sh; t = longint'(sl) & m; end
    endcase
    return {c, t[31:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] r,
                           input logic c);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_res"},   ALU_Out, r);
    check({tag, "_carry"}, 32'(CarryOut), 32'(c));
    check({tag, "_zero"},  32'(Zero), 32'(r == 32'd0));
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; A = a; B = b; ALU_Sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] s, input logic [31:0] er, input logic ec);
    issue(a, b, s);
    check_out(tag, 1'b1, er, ec);
    hold_r = er; hold_c = ec;
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    A = $urandom; B = $urandom; ALU_Sel = 4'($urandom_range(15));
    @(posedge clk);
    #1;
    check_out(tag, 1'b0, hold_r, hold_c);
  endtask

  initial begin
    logic [32:0] m;
    logic [31:0] ra, rb;
    logic [3:0]  rs;

    rst = 1'b1; in_valid = 1'b1; A = 32'd7; B = 32'd9; ALU_Sel = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 32'd0, 1'b0);

    // Reset wins over a valid op issued in the same cycle.
    run("pre_rst", 32'd5, 32'd3, 4'd0, 32'd8, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; A = 32'hFFFF_FFFF; B = 32'd1; ALU_Sel = 4'd0;
    @(posedge clk);
    #1;
    check_out("rst_override", 1'b0, 32'd0, 1'b0);
    hold_r = 32'd0; hold_c = 1'b0;

    run("add",      32'd5,          32'd3,          4'd0, 32'd8,          1'b0);
    run("add_wrap", 32'hFFFF_FFFF,  32'd1,          4'd0, 32'd0,          1'b1);
    run("sub",      32'd5,          32'd3,          4'd1, 32'd2,          1'b0);
    run("sub_brw",  32'd3,          32'd5,          4'd1, 32'hFFFF_FFFE,  1'b1);
`ifdef ALU_MULDIV_EN
    run("mul",      32'd2,          32'd3,          4'd2, 32'd6,          1'b0);
    run("divu",     32'd6,          32'd2,          4'd3, 32'd3,          1'b0);
    run("div0",     32'd6,          32'd0,          4'd3, 32'hFFFF_FFFF,  1'b0);
`else
    run("mul_off",  32'd2,          32'd3,          4'd2, 32'd0,          1'b0);
    run("div_off",  32'd6,          32'd2,          4'd3, 32'd0,          1'b0);
`endif
    run("sll",      32'd1,          32'd4,          4'd4, 32'h10,         1'b0);
    run("srl",      32'd2,          32'd1,          4'd5, 32'd1,          1'b0);
    run("rol",      32'h8000_0000,  32'd1,          4'd6, 32'd1,          1'b0);
    run("rol0",     32'h1234_5678,  32'hFFFF_FFE0,  4'd6, 32'h1234_5678,  1'b0);
    run("ror",      32'h8000_0000,  32'd1,          4'd7, 32'h4000_0000,  1'b0);
    run("sra",      32'hFFFF_FFF8,  32'd2,          4'd15, 32'hFFFF_FFFE, 1'b0);
    run("sll_hib",  32'd1,          32'hFFFF_FF04,  4'd4, 32'h10,         1'b0);
    run("and",      32'hF0F0_F0F0,  32'h0F0F_0F0F,  4'd8, 32'd0,          1'b0);
    run("or",       32'hF0F0_F0F0,  32'h0F0F_0F0F,  4'd9, 32'hFFFF_FFFF,  1'b0);
    run("xor",      32'hF0F0_F0F0,  32'h0F0F_0F0F,  4'd10, 32'hFFFF_FFFF, 1'b0);
    run("nor",      32'hF0F0_F0F0,  32'h0F0F_0F0F,  4'd11, 32'd0,         1'b0);
    run("nand",     32'hF0F0_F0F0,  32'h0F0F_0F0F,  4'd12, 32'hFFFF_FFFF, 1'b0);
    run("sltu",     32'd5,          32'd10,         4'd13, 32'd1,         1'b0);
    run("slt",      32'hFFFF_FFFB,  32'hFFFF_FFF6,  4'd14, 32'd0,         1'b0);
    run("sltu_neg", 32'hFFFF_FFFB,  32'd5,          4'd13, 32'd0,         1'b0);
    run("slt_neg",  32'hFFFF_FFFB,  32'd5,          4'd14, 32'd1,         1'b0);
    idle("hold1");
    idle("hold2");
    run("after_hold", 32'd1, 32'd1, 4'd0, 32'd2, 1'b0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        idle("rnd_idle");
      end else begin
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(3) == 0) rb = 32'($urandom_range(40));
        if ($urandom_range(7) == 0) rb = ra;
        rs = 4'($urandom_range(15));
        m  = model(ra, rb, rs);
        run("rnd_op", ra, rb, rs, m[31:0], m[32]);
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
